aes256_key_expand: RTL and testbench

- Upstream stage that feeds the round-key word consumed by the column mix/add-round-key stage.
- Expands a 256-bit AES key into the 60-word FIPS-197 schedule, w0..w59, producing one 32-bit word per advance.
- Round r uses words 4r..4r+3, in column order 0..3.
- Holds an 8-word sliding window, so the full schedule is never stored.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox_w.sv | 12 +
 rtl/aes256_key_expand.sv | 126 ++++++++++++
 tb/tb_aes256_key_expand.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 key schedule: schedule sizes, round
// constants, the byte S-box table and the word/state types.
package aes_pkg;

  localparam int NUM_WORDS = 60;
  localparam int NK        = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry 0 is never used: generation with i%8==0 starts at i=8.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_w.sv
// SubWord: four parallel byte S-box lookups on a 32-bit word (combinational).
module aes_sbox_w
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key expansion: streams w0..w59 one word per advance from an
// 8-word sliding window. Optional macro AES_KEY_ZEROIZE_EN wipes the window
// on completion and clears rnd_key the cycle after key_done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no valid key; waiting for key_load
// ST_RUN  | rnd_key holds w[word_idx]; key_adv steps to the next word
// ST_DONE | w59 consumed; key_done high for this single cycle
module aes256_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [255:0] key_in,
  input  logic         key_adv,
  output logic [31:0]  rnd_key,
  output logic         key_valid,
  output logic [5:0]   word_idx,
  output logic         key_done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  word_t      r_win [NK];
  word_t      r_rnd_key;
  logic       r_valid;
  logic       r_done;
  logic [5:0] r_idx;

  logic       w_adv;
  logic [5:0] w_idx_nxt;
  word_t      w_rot;
  word_t      w_sub_in;
  word_t      w_sub_out;
  word_t      w_t;
  word_t      w_g;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: a load restarts from any state and beats a simultaneous advance.
  always_comb begin
    w_state_nxt = r_state;
    if (key_load) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_adv && r_idx == LAST_IDX) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Control strobe and next schedule word; i = word_idx+1 picks the transform.
  always_comb begin
    w_adv     = key_adv && r_valid && (r_state == ST_RUN) && !key_load;
    w_idx_nxt = r_idx + 6'd1;
    w_rot     = {r_win[NK-1][23:0], r_win[NK-1][31:24]};
    w_sub_in  = (w_idx_nxt[2:0] == 3'd0) ? w_rot : r_win[NK-1];
    case (w_idx_nxt[2:0])
      3'd0:    w_t = w_sub_out ^ {RCON[w_idx_nxt[5:3]], 24'h0};
      3'd4:    w_t = w_sub_out;
      default: w_t = r_win[NK-1];
    endcase
    w_g = r_win[0] ^ w_t;
  end

  aes_sbox_w u_sbox (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Window, output word, index and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
      r_rnd_key <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
    end else if (key_load) begin
      for (int k = 0; k < NK; k++) r_win[k] <= key_in[255-32*k -: 32];
      r_rnd_key <= key_in[255:224];
      r_valid   <= 1'b1;
      r_done    <= 1'b0;
      r_idx     <= '0;
    end else if (w_adv) begin
      if (r_idx == LAST_IDX) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
        for (int k = 0; k < NK; k++) r_win[k] <= '0;
`endif
      end else begin
        r_idx <= w_idx_nxt;
        // The first eight words are the key itself, already in the window.
        if (w_idx_nxt[5:3] == 3'd0) begin
          r_rnd_key <= r_win[w_idx_nxt[2:0]];
        end else begin
          r_rnd_key <= w_g;
          for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
          r_win[NK-1] <= w_g;
        end
      end
    end else begin
      r_done <= 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
      if (r_state == ST_DONE) r_rnd_key <= '0;
`endif
    end
  end

  assign rnd_key   = r_rnd_key;
  assign key_valid = r_valid;
  assign word_idx  = r_idx;
  assign key_done  = r_done;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench for aes256_key_expand. The reference schedule is
// computed from first principles: S-box from GF(2^8) inversion plus the
// affine map, Rcon by repeated doubling, and the textbook w[i]=w[i-8]^temp.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_adv = 1'b0;
  logic [31:0]  rnd_key;
  logic         key_valid;
  logic [5:0]   word_idx;
  logic         key_done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  sb [256];
  logic [7:0]  rc [8];
  logic [31:0] ew [60];
  int          m_idx;
  logic [31:0] hold_exp;

  always #5 clk = ~clk;

  aes256_key_expand dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_adv   (key_adv),
    .rnd_key   (rnd_key),
    .key_valid (key_valid),
    .word_idx  (word_idx),
    .key_done  (key_done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, r;
    for (int b = 0; b < 256; b++) begin
      inv = '0;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sb[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    r = 8'h01;
    rc[0] = 8'h00;
    for (int j = 1; j < 8; j++) begin
      rc[j] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_sched(input logic [255:0] key);
    logic [31:0] t;
    for (int k = 0; k < 8; k++) ew[k] = key[255-32*k -: 32];
    for (int i = 8; i < 60; i++) begin
      t = ew[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {rc[i/8], 24'h0};
      else if (i % 8 == 4) t = subw(t);
      ew[i] = ew[i-8] ^ t;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int k);
    check("rnd_key", rnd_key, ew[k]);
    check("word_idx", 32'(word_idx), 32'(k));
    check("key_valid", 32'(key_valid), 32'd1);
    check("key_done_low", 32'(key_done), 32'd0);
  endtask

  task automatic load_key(input logic [255:0] key);
    build_sched(key);
    key_in = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    m_idx = 0;
    expect_word(0);
  endtask

  task automatic run_to(input int target);
    key_adv = 1'b1;
    while (m_idx < target) begin
      tick();
      m_idx++;
      expect_word(m_idx);
    end
  endtask

  task automatic finish_run();
    key_adv = 1'b1;
    tick();
    check("done_pulse", 32'(key_done), 32'd1);
    check("done_valid", 32'(key_valid), 32'd0);
    check("done_rnd_key", rnd_key, ew[59]);
    tick();
    check("done_drop", 32'(key_done), 32'd0);
    check("post_valid", 32'(key_valid), 32'd0);
    check("post_rnd_key", rnd_key, hold_exp);
    tick();
    check("idle_ignore_adv", 32'(key_valid), 32'd0);
    check("idle_rnd_key", rnd_key, hold_exp);
    key_adv = 1'b0;
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    logic [255:0] k;
    bit got_done;
    int budget;
    build_tables();

    // Reset values.
    tick();
    check("rst_rnd_key", rnd_key, 32'h0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_idx", 32'(word_idx), 32'd0);
    check("rst_done", 32'(key_done), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_done2", 32'(key_done), 32'd0);

    // Key 00..1f with key_adv held high.
    load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("k1_w0", rnd_key, 32'h00010203);
    run_to(1);
    check("k1_w1", rnd_key, 32'h04050607);
    run_to(7);
    check("k1_w7", rnd_key, 32'h1c1d1e1f);
    run_to(8);
    check("k1_w8", rnd_key, 32'ha573c29f);
    run_to(56);
    check("k1_w56", rnd_key, 32'h24fc79cc);
    run_to(57);
    check("k1_w57", rnd_key, 32'hbf0979e9);
    run_to(58);
    check("k1_w58", rnd_key, 32'h371ac23c);
    run_to(59);
    check("k1_w59", rnd_key, 32'h6d68de36);
`ifdef AES_KEY_ZEROIZE_EN
    hold_exp = 32'h0;
`else
    hold_exp = ew[59];
`endif
    finish_run();

    // Second known-answer key.
    load_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_to(8);
    check("k2_w8", rnd_key, 32'h9ba35411);
    run_to(9);
    check("k2_w9", rnd_key, 32'h8e6925af);
    run_to(59);
    check("k2_w59", rnd_key, 32'h706c631e);
`ifdef AES_KEY_ZEROIZE_EN
    hold_exp = 32'h0;
`else
    hold_exp = ew[59];
`endif
    finish_run();

    // Sparse advance: one pulse every 4 cycles on a random key.
    load_key(rand_key());
    for (int p = 0; p < 12; p++) begin
      key_adv = 1'b1;
      tick();
      key_adv = 1'b0;
      m_idx++;
      expect_word(m_idx);
      for (int q = 0; q < 3; q++) begin
        tick();
        expect_word(m_idx);
      end
    end

    // Restart at word 20 with key_adv also high: the advance is dropped.
    run_to(20);
    k = rand_key();
    build_sched(k);
    key_in = k;
    key_load = 1'b1;
    key_adv = 1'b1;
    tick();
    key_load = 1'b0;
    m_idx = 0;
    expect_word(0);
    run_to(33);

    // Reset mid-run at word 33.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_rnd_key", rnd_key, 32'h0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_idx", 32'(word_idx), 32'd0);
    check("midrst_done", 32'(key_done), 32'd0);
    for (int q = 0; q < 3; q++) begin
      tick();
      check("rst_adv_ignored_idx", 32'(word_idx), 32'd0);
      check("rst_adv_ignored_valid", 32'(key_valid), 32'd0);
      check("rst_adv_ignored_rnd", rnd_key, 32'h0);
    end
    key_adv = 1'b0;

    // Random key with a random advance pattern, run to completion.
    load_key(rand_key());
    got_done = 1'b0;
    budget = 0;
    while (!got_done && budget < 1000) begin
      key_adv = 1'($urandom_range(0, 1));
      tick();
      budget++;
      if (key_adv && m_idx == 59) begin
        got_done = 1'b1;
        check("rand_done_pulse", 32'(key_done), 32'd1);
        check("rand_done_rnd", rnd_key, ew[59]);
      end else begin
        if (key_adv) m_idx++;
        expect_word(m_idx);
      end
    end
    key_adv = 1'b0;
    if (!got_done) check("rand_run_timeout", 32'(budget), 32'd0);
    tick();
    check("rand_done_drop", 32'(key_done), 32'd0);
`ifdef AES_KEY_ZEROIZE_EN
    check("rand_zeroized", rnd_key, 32'h0);
`else
    check("rand_retained", rnd_key, ew[59]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
